// File: rtl/sram_refill_ctrl_pkg.sv
// Shared constants, AXI encodings and FSM state type for the cache-line refill engine.
package sram_refill_ctrl_pkg;
   localparam int ADDR_W        = 32;
   localparam int INDEX_W       = 7;
   localparam int LINE_BITS     = 128;
   localparam int BEAT_BITS     = 64;
   localparam int BEATS         = LINE_BITS / BEAT_BITS;
   localparam int BEAT_CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LINE_OFFSET_W = $clog2(LINE_BITS / 8);

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [7:0] AXI_LEN_LINE   = 8'(BEATS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_FLUSH,
      ST_DONE
   } refill_state_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
   endfunction
endpackage

// File: rtl/sram_refill_ctrl_if.sv
// Request/completion, AXI read (AR/R) and SRAM write bundle of the refill engine.
interface sram_refill_ctrl_if;
   import sram_refill_ctrl_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic [ADDR_W-1:0]    req_addr;
   logic [INDEX_W-1:0]   req_index;
   logic                 done_valid;
   logic                 done_err;
   logic                 ar_valid;
   logic                 ar_ready;
   logic [ADDR_W-1:0]    ar_addr;
   logic [7:0]           ar_len;
   logic [2:0]           ar_size;
   logic [1:0]           ar_burst;
   logic                 r_valid;
   logic                 r_ready;
   logic [BEAT_BITS-1:0] r_data;
   logic [1:0]           r_resp;
   logic                 r_last;
   logic                 sram_cen;
   logic                 sram_wen;
   logic [LINE_BITS-1:0] sram_bwen;
   logic [INDEX_W-1:0]   sram_a;
   logic [LINE_BITS-1:0] sram_d;

   modport master (
      input  req_valid, req_addr, req_index, ar_ready, r_valid, r_data, r_resp, r_last,
      output req_ready, done_valid, done_err, ar_valid, ar_addr, ar_len, ar_size, ar_burst,
      output r_ready, sram_cen, sram_wen, sram_bwen, sram_a, sram_d
   );

   modport slave (
      output req_valid, req_addr, req_index, ar_ready, r_valid, r_data, r_resp, r_last,
      input  req_ready, done_valid, done_err, ar_valid, ar_addr, ar_len, ar_size, ar_burst,
      input  r_ready, sram_cen, sram_wen, sram_bwen, sram_a, sram_d
   );
endinterface

// File: rtl/sram_refill_ctrl_beat_mask.sv
// Active-low SRAM bit-write mask that opens only the lane of the given beat.
module refill_beat_mask
   import sram_refill_ctrl_pkg::*;
(
   input  logic [BEAT_CNT_W-1:0] beat,
   output logic [LINE_BITS-1:0]  mask
);
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      assign mask[gi*BEAT_BITS +: BEAT_BITS] = (beat == BEAT_CNT_W'(gi)) ? '0 : '1;
   end
endmodule

// File: rtl/sram_refill_ctrl.sv
// Cache-line refill engine: one AXI INCR read burst per miss, each beat written
// into the destination SRAM line through a per-beat bit mask.
module sram_refill_ctrl
   import sram_refill_ctrl_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_N,
   sram_refill_ctrl_if.master bus
);
   refill_state_t        state_reg;
   logic [BEAT_CNT_W-1:0] beat_cnt_reg;
   logic                 err_reg;
   logic [INDEX_W-1:0]   index_reg;
   logic                 req_ready_reg;
   logic                 done_valid_reg;
   logic                 done_err_reg;
   logic                 ar_valid_reg;
   logic [ADDR_W-1:0]    ar_addr_reg;
   logic                 r_ready_reg;
   logic                 sram_cen_reg;
   logic                 sram_wen_reg;
   logic [LINE_BITS-1:0] sram_bwen_reg;
   logic [INDEX_W-1:0]   sram_a_reg;
   logic [LINE_BITS-1:0] sram_d_reg;
   logic [LINE_BITS-1:0] beat_mask;
   logic                 beat_fire;
   logic                 last_slot;

   assign beat_fire = r_ready_reg & bus.r_valid;
   assign last_slot = (beat_cnt_reg == BEAT_CNT_W'(BEATS - 1));

   refill_beat_mask u_beat_mask (
      .beat (beat_cnt_reg),
      .mask (beat_mask)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg      <= ST_IDLE;
         beat_cnt_reg   <= '0;
         err_reg        <= 1'b0;
         index_reg      <= '0;
         req_ready_reg  <= 1'b1;
         done_valid_reg <= 1'b0;
         done_err_reg   <= 1'b0;
         ar_valid_reg   <= 1'b0;
         ar_addr_reg    <= '0;
         r_ready_reg    <= 1'b0;
         sram_cen_reg   <= 1'b1;
         sram_wen_reg   <= 1'b1;
         sram_bwen_reg  <= '1;
         sram_a_reg     <= '0;
         sram_d_reg     <= '0;
      end else begin
         // SRAM idles unless a beat was accepted in the previous cycle
         sram_cen_reg   <= 1'b1;
         sram_wen_reg   <= 1'b1;
         sram_bwen_reg  <= '1;
         done_valid_reg <= 1'b0;
         done_err_reg   <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  ar_addr_reg   <= line_align(bus.req_addr);
                  index_reg     <= bus.req_index;
                  beat_cnt_reg  <= '0;
                  err_reg       <= 1'b0;
                  ar_valid_reg  <= 1'b1;
                  req_ready_reg <= 1'b0;
                  state_reg     <= ST_AR;
               end
            end
            ST_AR: begin
               if (bus.ar_ready) begin
                  ar_valid_reg <= 1'b0;
                  r_ready_reg  <= 1'b1;
                  state_reg    <= ST_R;
               end
            end
            ST_R: begin
               if (beat_fire) begin
                  sram_cen_reg  <= 1'b0;
                  sram_wen_reg  <= 1'b0;
                  sram_bwen_reg <= beat_mask;
                  sram_a_reg    <= index_reg;
                  sram_d_reg    <= {BEATS{bus.r_data}};
                  // r_last must coincide with the final slot; early or missing is corrupt
                  if (bus.r_resp != AXI_RESP_OKAY || bus.r_last != last_slot) begin
                     err_reg <= 1'b1;
                  end
                  if (bus.r_last || last_slot) begin
                     r_ready_reg <= 1'b0;
                     state_reg   <= ST_FLUSH;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
                  end
               end
            end
            ST_FLUSH: begin
               done_valid_reg <= 1'b1;
               done_err_reg   <= err_reg;
               state_reg      <= ST_DONE;
            end
            ST_DONE: begin
               req_ready_reg <= 1'b1;
               state_reg     <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_reg;
   assign bus.done_valid = done_valid_reg;
   assign bus.done_err   = done_err_reg;
   assign bus.ar_valid   = ar_valid_reg;
   assign bus.ar_addr    = ar_addr_reg;
   assign bus.ar_len     = AXI_LEN_LINE;
   assign bus.ar_size    = AXI_SIZE_8B;
   assign bus.ar_burst   = AXI_BURST_INCR;
   assign bus.r_ready    = r_ready_reg;
   assign bus.sram_cen   = sram_cen_reg;
   assign bus.sram_wen   = sram_wen_reg;
   assign bus.sram_bwen  = sram_bwen_reg;
   assign bus.sram_a     = sram_a_reg;
   assign bus.sram_d     = sram_d_reg;
endmodule

// File: doc/sram_refill_ctrl.md
Name: sram_refill_ctrl

Overview:
- Cache-line refill engine sitting directly upstream of the 128x128 bit-masked line SRAM.
- On a miss request it issues one AXI4 INCR read burst of two 64-bit beats.
- Each returned beat is written into the addressed SRAM line using the SRAM's active-low bit-write mask.
- Signals completion, with error status, to the cache FSM.

Parameters:
- ADDR_W, 32, memory address width
- INDEX_W, 7, SRAM line index width (128 lines)
- LINE_BITS, 128, SRAM word/line width
- BEAT_BITS, 64, AXI read data width; BEATS = LINE_BITS/BEAT_BITS = 2

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  1  refill request
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  miss address; low 4 bits ignored
- req_index  in  INDEX_W  destination SRAM line
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done_valid; 1 = line corrupt, do not validate
- ar_valid/ar_ready  out/in  1  AXI AR handshake
- ar_addr  out  ADDR_W  line-aligned address
- ar_len  out  8  constant BEATS-1
- ar_size  out  3  constant 3'b011
- ar_burst  out  2  constant 2'b01
- r_valid/r_ready  in/out  1  AXI R handshake
- r_data  in  BEAT_BITS  beat data
- r_resp  in  2  nonzero = error
- r_last  in  1  final beat
- sram_cen  out  1  SRAM chip enable, active low
- sram_wen  out  1  SRAM write enable, active low
- sram_bwen  out  LINE_BITS  bit-write mask, active low
- sram_a  out  INDEX_W  SRAM address
- sram_d  out  LINE_BITS  SRAM write data

Behaviour:
- Reset values (async, all outputs registered):
  - state=IDLE, req_ready=1, done_valid=0, done_err=0
  - ar_valid=0, r_ready=0, ar_addr=0
  - sram_cen=1, sram_wen=1, sram_bwen=all ones, sram_a=0, sram_d=0
  - beat counter=0, error flag=0
- FSM states: IDLE -> AR -> R -> FLUSH -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch {req_addr[ADDR_W-1:4], 4'b0} and req_index; clear counter and error flag.
  - Move to AR; ar_valid asserts the next cycle.
- AR:
  - ar_valid held high and ar_addr held stable until ar_ready; then move to R.
  - r_ready is never asserted before the AR handshake.
- R:
  - r_ready=1 continuously; the SRAM never stalls.
  - On a handshake with beat count k, the next cycle drives one write: sram_cen=0, sram_wen=0, sram_a=index, sram_d={r_data,r_data}.
  - The write mask is sram_bwen[64k+63:64k]=0, all other bits 1.
  - A non-handshake cycle reverts to sram_cen=1, sram_wen=1, bwen all ones.
- Error flag (sticky) is set on any beat with r_resp!=0, and on r_last arriving with k<BEATS-1. Writes still occur.
- Terminal beat is the first of: r_last=1, or k==BEATS-1. On the terminal beat go to FLUSH.
- If k==BEATS-1 and r_last=0: set the error flag, drop r_ready, and discard later beats.
- FLUSH: carries the final SRAM write; r_ready=0.
- DONE: done_valid=1 for exactly one cycle, done_err=error flag; then IDLE.
- Minimum latency with zero-wait memory: request accepted at cycle 0, ar_valid at 1, beats at 2 and 3, SRAM writes at 3 and 4, done_valid at 5.
- Back-to-back: next request accepted in the cycle after DONE.
- Reset asserted mid-operation:
  - All state and outputs return to reset values immediately.
  - Any in-flight SRAM write is deasserted, and the outstanding AXI burst is abandoned.
  - The interconnect shares the reset.
- Never issues read cycles; sram_wen=0 only while sram_cen=0.

Decomposition:
- Shared package holds: AXI constants (burst INCR, size-8B, resp OKAY), the refill FSM state enum, and LINE_BITS/BEAT_BITS/BEATS/INDEX_W.
- One natural sub-module, refill_beat_mask: maps beat index to the active-low LINE_BITS mask.

Test Plan:
- Basic refill: req addr 0x8000_1234, index 5, ar_ready=1, beats 0x1111..., 0x2222... (last). Expect:
  - ar_addr=0x8000_1230, ar_len=1.
  - Write 1: a=5, bwen[63:0]=0, upper half 1s.
  - Write 2: bwen[127:64]=0.
  - done_valid at cycle 5 with done_err=0.
- AR backpressure: ar_ready low 3 cycles -> ar_valid and ar_addr held stable, r_ready=0, done_valid delayed exactly 3 cycles.
- Beat gaps: r_valid low 2 cycles between beats -> no SRAM activity in the gap (cen=1), both writes correct.
- Error resp: beat 0 r_resp=2'b10 -> both writes still issued, done_err=1.
- Early r_last on beat 0 -> a single write of the lower half, FLUSH, done_err=1, return to IDLE.
- Reset mid-burst: RST_N low after beat 0 -> sram_cen=1 asynchronously, req_ready=1. A new request after reset completes normally with done_err=0.
